rx_ack_sched: RTL and testbench
===============================

Name: rx_ack_sched

Overview:
- Per-flow RX acknowledgement controller for the TCP slow path.
- Holds per-flow receive state: expected ack number, RX payload-slot tail/head indices and last advertised window.
- Sequences each arriving data segment through an in-order/space check and a payload-buffer malloc handshake.
- Commits the new ack/tail/window and reports the result to the TX/ACK generation path.

Parameters:
- NUM_FLOWS, 8, number of tracked flows; FLOWID_W = $clog2(NUM_FLOWS).
- ACK_NUM_W, 32, ack/seq width.
- LEN_W, 16, payload length width.
- RX_IDX_W, 3, log2 of RX payload slots per flow; index registers are RX_IDX_W+1 bits.
- WIN_W, 17, window/approx-space width.

Ports:
- clk in 1 clock
- rst in 1 asynchronous active-high reset
- init_val in 1 connection-open request
- init_flowid in FLOWID_W flow being opened
- init_ack_num in ACK_NUM_W initial expected seq
- init_win in WIN_W initial window
- init_rdy out 1 init accepted
- pkt_val in 1 data segment request
- pkt_flowid in FLOWID_W segment flow
- pkt_seq_num in ACK_NUM_W segment seq
- pkt_len in LEN_W payload bytes
- pkt_rdy out 1 segment accepted
- malloc_req_val out 1 buffer request
- malloc_req_flowid out FLOWID_W flow of request
- malloc_req_len out LEN_W bytes requested
- malloc_req_rdy in 1 allocator took request
- malloc_resp_val in 1 allocator response
- malloc_resp_success in 1 allocation granted
- malloc_resp_space in WIN_W approximate free space after this request
- malloc_resp_rdy out 1 response consumed
- head_upd_val in 1 app consumed slots
- head_upd_flowid in FLOWID_W flow
- head_upd_idx in RX_IDX_W+1 new head index
- res_val out 1 result valid
- res_flowid out FLOWID_W flow
- res_accept out 1 payload accepted
- res_ack_num out ACK_NUM_W ack to send
- res_slot_idx out RX_IDX_W+1 slot written (old tail); 0 if not accepted
- res_win out WIN_W window to advertise
- res_rdy in 1 consumer took result

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - All per-flow arrays and the latched request are 0.
  - All outputs 0.
- FSM states: IDLE, CHECK, MREQ, MRESP, RESULT. One segment in flight.
- IDLE:
  - init_rdy = 1. pkt_rdy = ~init_val, so init has priority.
  - Init handshake: flow ack = init_ack_num, tail = head = 0, win = init_win. Stay IDLE.
  - Pkt handshake: latch flowid/seq/len, go CHECK.
- CHECK (1 cycle):
  - Read flow state.
  - used = tail - head, mod 2^(RX_IDX_W+1).
  - Proceed iff seq == ack and used < 2^RX_IDX_W; go MREQ.
  - Otherwise load a dup result (accept=0, stored ack, stored win) and go RESULT. No malloc is issued for out-of-order or slot-full segments.
- MREQ:
  - malloc_req_val = 1 with latched flowid/len.
  - On malloc_req_rdy, go MRESP.
- MRESP:
  - malloc_resp_rdy = 1.
  - On malloc_resp_val with success:
    - ack = seq + len, mod 2^ACK_NUM_W.
    - slot = old tail; tail += 1 (wraps at RX_IDX_W+1 bits).
    - win = malloc_resp_space - len, saturating at 0.
    - Write ack, tail and win to the flow state.
  - On malloc_resp_val with failure: accept=0, stored ack, win = malloc_resp_space; write the new win only.
  - Either case: go RESULT.
- RESULT:
  - res_* outputs are registered and held stable while res_val=1 and res_rdy=0.
  - On res_rdy, go IDLE.
- Latency from the pkt handshake edge:
  - Dup/full: res_val asserts 2 cycles later.
  - Accepted with zero-wait allocator (rdy/resp same cycle they are requested/expected): res_val asserts 4 cycles later.
- Head update:
  - Always accepted (no rdy); writes head the next edge, any state.
  - Same-flow update during CHECK: the old head is used. This is conservative only.
  - Head and tail/ack/win are separate fields, so there are no write conflicts.
- Init targeting the in-flight flow cannot occur, because init is only accepted in IDLE.
- Reset mid-operation: everything returns to the reset state. Any outstanding malloc is abandoned and must be reset together with the allocator.

Test Plan:
- Reset, then init flow 2 (ack=1000, win=4096), then pkt flow 2 (seq=1000, len=100); allocator resp success, space=4000 -> malloc_req len=100; res accept=1, ack=1100, slot=0, win=3900; tail=1.
- Same flow, pkt seq=1200 (out of order) -> no malloc_req_val ever; res_val 2 cycles after handshake; accept=0, ack=1100, win=3900.
- Fill 8 slots with in-order pkts, then a 9th -> accept=0, no malloc. Then head_upd idx=3 and pkt -> accepted, slot=8 (tail wraps 15→0 later without error).
- Malloc failure (success=0, space=50) on an in-order pkt -> accept=0, ack unchanged, win=50. A later pkt with space=20, len=40 -> win saturates at 0.
- Backpressure: hold malloc_req_rdy=0 for 5 cycles and res_rdy=0 for 3 cycles -> req and res fields stable throughout, pkt_rdy=0 until return to IDLE. init_val together with pkt_val in IDLE -> init taken first.
- Wrap: ack=0xFFFF_FFF0, pkt len=0x20 -> ack=0x10. Assert rst during MRESP -> all outputs 0 immediately, state arrays cleared.

Source files
------------

// File: rtl/rx_ack_sched.sv
// rx_ack_sched: per-flow RX acknowledgement controller. Checks each arriving
// segment for in-order delivery and slot space, obtains a payload buffer from
// the allocator, then commits ack/tail/window and reports the result.
module rx_ack_sched #(
   parameter int unsigned NUM_FLOWS = 8,
   parameter int unsigned ACK_NUM_W = 32,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned RX_IDX_W  = 3,
   parameter int unsigned WIN_W     = 17,
   localparam int unsigned FLOWID_W = $clog2(NUM_FLOWS),
   localparam int unsigned IDX_W    = RX_IDX_W + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_val,
   input  logic [FLOWID_W-1:0]  init_flowid,
   input  logic [ACK_NUM_W-1:0] init_ack_num,
   input  logic [WIN_W-1:0]     init_win,
   output logic                 init_rdy,
   input  logic                 pkt_val,
   input  logic [FLOWID_W-1:0]  pkt_flowid,
   input  logic [ACK_NUM_W-1:0] pkt_seq_num,
   input  logic [LEN_W-1:0]     pkt_len,
   output logic                 pkt_rdy,
   output logic                 malloc_req_val,
   output logic [FLOWID_W-1:0]  malloc_req_flowid,
   output logic [LEN_W-1:0]     malloc_req_len,
   input  logic                 malloc_req_rdy,
   input  logic                 malloc_resp_val,
   input  logic                 malloc_resp_success,
   input  logic [WIN_W-1:0]     malloc_resp_space,
   output logic                 malloc_resp_rdy,
   input  logic                 head_upd_val,
   input  logic [FLOWID_W-1:0]  head_upd_flowid,
   input  logic [IDX_W-1:0]     head_upd_idx,
   output logic                 res_val,
   output logic [FLOWID_W-1:0]  res_flowid,
   output logic                 res_accept,
   output logic [ACK_NUM_W-1:0] res_ack_num,
   output logic [IDX_W-1:0]     res_slot_idx,
   output logic [WIN_W-1:0]     res_win,
   input  logic                 res_rdy
);

   localparam int unsigned SLOTS = 1 << RX_IDX_W;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CHECK, ST_MREQ, ST_MRESP, ST_RESULT
   } state_t;

   state_t state_q, state_d;

   // per-flow receive state
   logic [ACK_NUM_W-1:0] ack_q  [NUM_FLOWS];
   logic [ACK_NUM_W-1:0] ack_d  [NUM_FLOWS];
   logic [IDX_W-1:0]     tail_q [NUM_FLOWS];
   logic [IDX_W-1:0]     tail_d [NUM_FLOWS];
   logic [IDX_W-1:0]     head_q [NUM_FLOWS];
   logic [IDX_W-1:0]     head_d [NUM_FLOWS];
   logic [WIN_W-1:0]     win_q  [NUM_FLOWS];
   logic [WIN_W-1:0]     win_d  [NUM_FLOWS];

   // latched in-flight segment
   logic [FLOWID_W-1:0]  lat_flow_q, lat_flow_d;
   logic [ACK_NUM_W-1:0] lat_seq_q, lat_seq_d;
   logic [LEN_W-1:0]     lat_len_q, lat_len_d;

   // registered handshake outputs and result
   logic                 init_rdy_q, init_rdy_d;
   logic                 req_val_q, req_val_d;
   logic                 resp_rdy_q, resp_rdy_d;
   logic                 res_val_q, res_val_d;
   logic [FLOWID_W-1:0]  res_flow_q, res_flow_d;
   logic                 res_acc_q, res_acc_d;
   logic [ACK_NUM_W-1:0] res_ack_q, res_ack_d;
   logic [IDX_W-1:0]     res_slot_q, res_slot_d;
   logic [WIN_W-1:0]     res_win_q, res_win_d;

   logic                 init_hs, pkt_hs;
   logic [IDX_W-1:0]     used;
   logic                 can_go;
   logic [ACK_NUM_W-1:0] new_ack;
   logic [WIN_W-1:0]     len_w;
   logic [WIN_W-1:0]     win_sat;

   assign init_hs = init_val & init_rdy_q;
   assign pkt_hs  = pkt_val & init_rdy_q & ~init_val;

   // next-state, flow-state update and registered-output computation
   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      tail_d     = tail_q;
      head_d     = head_q;
      win_d      = win_q;
      lat_flow_d = lat_flow_q;
      lat_seq_d  = lat_seq_q;
      lat_len_d  = lat_len_q;
      res_val_d  = res_val_q;
      res_flow_d = res_flow_q;
      res_acc_d  = res_acc_q;
      res_ack_d  = res_ack_q;
      res_slot_d = res_slot_q;
      res_win_d  = res_win_q;

      used    = tail_q[lat_flow_q] - head_q[lat_flow_q];
      can_go  = (lat_seq_q == ack_q[lat_flow_q]) && (used < IDX_W'(SLOTS));
      new_ack = lat_seq_q + ACK_NUM_W'(lat_len_q);
      len_w   = WIN_W'(lat_len_q);
      win_sat = (malloc_resp_space > len_w) ? (malloc_resp_space - len_w) : '0;

      case (state_q)
         ST_IDLE: begin
            if (init_hs) begin
               ack_d[init_flowid]  = init_ack_num;
               tail_d[init_flowid] = '0;
               head_d[init_flowid] = '0;
               win_d[init_flowid]  = init_win;
            end else if (pkt_hs) begin
               lat_flow_d = pkt_flowid;
               lat_seq_d  = pkt_seq_num;
               lat_len_d  = pkt_len;
               state_d    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (can_go) begin
               state_d = ST_MREQ;
            end else begin
               res_flow_d = lat_flow_q;
               res_acc_d  = 1'b0;
               res_ack_d  = ack_q[lat_flow_q];
               res_slot_d = '0;
               res_win_d  = win_q[lat_flow_q];
               state_d    = ST_RESULT;
            end
         end
         ST_MREQ: begin
            if (malloc_req_rdy) state_d = ST_MRESP;
         end
         ST_MRESP: begin
            if (malloc_resp_val) begin
               res_flow_d = lat_flow_q;
               if (malloc_resp_success) begin
                  ack_d[lat_flow_q]  = new_ack;
                  tail_d[lat_flow_q] = tail_q[lat_flow_q] + IDX_W'(1);
                  win_d[lat_flow_q]  = win_sat;
                  res_acc_d  = 1'b1;
                  res_ack_d  = new_ack;
                  res_slot_d = tail_q[lat_flow_q];
                  res_win_d  = win_sat;
               end else begin
                  win_d[lat_flow_q] = malloc_resp_space;
                  res_acc_d  = 1'b0;
                  res_ack_d  = ack_q[lat_flow_q];
                  res_slot_d = '0;
                  res_win_d  = malloc_resp_space;
               end
               state_d = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (!res_val_q) begin
               res_val_d = 1'b1;
            end else if (res_rdy) begin
               res_val_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // application head updates are accepted in any state
      if (head_upd_val) head_d[head_upd_flowid] = head_upd_idx;

      init_rdy_d = (state_d == ST_IDLE);
      req_val_d  = (state_d == ST_MREQ);
      resp_rdy_d = (state_d == ST_MRESP);
   end

   // state, flow arrays and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < int'(NUM_FLOWS); i++) begin
            ack_q[i]  <= '0;
            tail_q[i] <= '0;
            head_q[i] <= '0;
            win_q[i]  <= '0;
         end
         lat_flow_q <= '0;
         lat_seq_q  <= '0;
         lat_len_q  <= '0;
         init_rdy_q <= 1'b0;
         req_val_q  <= 1'b0;
         resp_rdy_q <= 1'b0;
         res_val_q  <= 1'b0;
         res_flow_q <= '0;
         res_acc_q  <= 1'b0;
         res_ack_q  <= '0;
         res_slot_q <= '0;
         res_win_q  <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         tail_q     <= tail_d;
         head_q     <= head_d;
         win_q      <= win_d;
         lat_flow_q <= lat_flow_d;
         lat_seq_q  <= lat_seq_d;
         lat_len_q  <= lat_len_d;
         init_rdy_q <= init_rdy_d;
         req_val_q  <= req_val_d;
         resp_rdy_q <= resp_rdy_d;
         res_val_q  <= res_val_d;
         res_flow_q <= res_flow_d;
         res_acc_q  <= res_acc_d;
         res_ack_q  <= res_ack_d;
         res_slot_q <= res_slot_d;
         res_win_q  <= res_win_d;
      end
   end

   assign init_rdy          = init_rdy_q;
   assign pkt_rdy           = init_rdy_q & ~init_val;
   assign malloc_req_val    = req_val_q;
   assign malloc_req_flowid = lat_flow_q;
   assign malloc_req_len    = lat_len_q;
   assign malloc_resp_rdy   = resp_rdy_q;
   assign res_val           = res_val_q;
   assign res_flowid        = res_flow_q;
   assign res_accept        = res_acc_q;
   assign res_ack_num       = res_ack_q;
   assign res_slot_idx      = res_slot_q;
   assign res_win           = res_win_q;

endmodule

// File: tb/tb_rx_ack_sched.sv
// Bench for rx_ack_sched: directed scenarios plus random traffic, checked by
// a scoreboard fed from a per-flow reference model.
`timescale 1ns/1ps
module tb_rx_ack_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        init_val = 1'b0;
   logic [2:0]  init_flowid = '0;
   logic [31:0] init_ack_num = '0;
   logic [16:0] init_win = '0;
   logic        init_rdy;
   logic        pkt_val = 1'b0;
   logic [2:0]  pkt_flowid = '0;
   logic [31:0] pkt_seq_num = '0;
   logic [15:0] pkt_len = '0;
   logic        pkt_rdy;
   logic        malloc_req_val;
   logic [2:0]  malloc_req_flowid;
   logic [15:0] malloc_req_len;
   logic        malloc_req_rdy = 1'b0;
   logic        malloc_resp_val = 1'b0;
   logic        malloc_resp_success = 1'b0;
   logic [16:0] malloc_resp_space = '0;
   logic        malloc_resp_rdy;
   logic        head_upd_val = 1'b0;
   logic [2:0]  head_upd_flowid = '0;
   logic [3:0]  head_upd_idx = '0;
   logic        res_val;
   logic [2:0]  res_flowid;
   logic        res_accept;
   logic [31:0] res_ack_num;
   logic [3:0]  res_slot_idx;
   logic [16:0] res_win;
   logic        res_rdy = 1'b0;

   rx_ack_sched dut (
      .clk(clk), .rst(rst),
      .init_val(init_val), .init_flowid(init_flowid), .init_ack_num(init_ack_num),
      .init_win(init_win), .init_rdy(init_rdy),
      .pkt_val(pkt_val), .pkt_flowid(pkt_flowid), .pkt_seq_num(pkt_seq_num),
      .pkt_len(pkt_len), .pkt_rdy(pkt_rdy),
      .malloc_req_val(malloc_req_val), .malloc_req_flowid(malloc_req_flowid),
      .malloc_req_len(malloc_req_len), .malloc_req_rdy(malloc_req_rdy),
      .malloc_resp_val(malloc_resp_val), .malloc_resp_success(malloc_resp_success),
      .malloc_resp_space(malloc_resp_space), .malloc_resp_rdy(malloc_resp_rdy),
      .head_upd_val(head_upd_val), .head_upd_flowid(head_upd_flowid),
      .head_upd_idx(head_upd_idx),
      .res_val(res_val), .res_flowid(res_flowid), .res_accept(res_accept),
      .res_ack_num(res_ack_num), .res_slot_idx(res_slot_idx), .res_win(res_win),
      .res_rdy(res_rdy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  flow;
      logic        acc;
      logic [31:0] ack;
      logic [3:0]  slot;
      logic [16:0] win;
      int          lat;
      int          res_wait;
   } exp_t;

   typedef struct {
      logic        succ;
      logic [16:0] space;
      int          req_wait;
      int          resp_wait;
      bit          hang;
   } cfg_t;

   exp_t        exp_q[$];
   logic [18:0] mreq_q[$];
   cfg_t        cfg_q[$];

   // reference model: per-flow receive state
   logic [31:0] m_ack  [8];
   logic [3:0]  m_tail [8];
   logic [3:0]  m_head [8];
   logic [16:0] m_win  [8];

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int hs_cyc = 0;
   bit in_flight = 1'b0;
   bit abort = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_ack[i] = '0; m_tail[i] = '0; m_head[i] = '0; m_win[i] = '0;
      end
   endtask

   task automatic do_init(input logic [2:0] f, input logic [31:0] a, input logic [16:0] w);
      int t = 0;
      @(negedge clk);
      init_val = 1'b1; init_flowid = f; init_ack_num = a; init_win = w;
      while (!init_rdy && t < 50) begin @(negedge clk); t++; end
      if (!init_rdy) begin chk("init_rdy_timeout", 64'(init_rdy), 64'd1); abort = 1'b1; end
      @(posedge clk); #1;
      init_val = 1'b0;
      m_ack[f] = a; m_tail[f] = '0; m_head[f] = '0; m_win[f] = w;
   endtask

   task automatic do_head(input logic [2:0] f, input logic [3:0] idx);
      @(negedge clk);
      head_upd_val = 1'b1; head_upd_flowid = f; head_upd_idx = idx;
      @(negedge clk);
      head_upd_val = 1'b0;
      m_head[f] = idx;
   endtask

   // computes the expected outcome from the model, then drives one segment
   task automatic send_pkt(input logic [2:0] f, input logic [31:0] seq, input logic [15:0] len,
                           input logic succ, input logic [16:0] space,
                           input int rqw, input int rsw, input int resw, input bit hang,
                           input bit with_init, input logic [31:0] iack, input logic [16:0] iwin);
      exp_t e;
      cfg_t c;
      logic [3:0] used;
      int t = 0;
      int target;
      if (with_init) begin
         m_ack[f] = iack; m_tail[f] = '0; m_head[f] = '0; m_win[f] = iwin;
      end
      used = m_tail[f] - m_head[f];
      e.flow = f; e.res_wait = resw;
      if (seq != m_ack[f] || used >= 4'd8) begin
         e.acc = 1'b0; e.ack = m_ack[f]; e.slot = '0; e.win = m_win[f]; e.lat = 2;
         exp_q.push_back(e);
      end else begin
         mreq_q.push_back({f, len});
         c.succ = succ; c.space = space; c.req_wait = rqw; c.resp_wait = rsw; c.hang = hang;
         cfg_q.push_back(c);
         if (!hang) begin
            e.lat = 4 + rqw + rsw;
            if (succ) begin
               e.acc = 1'b1; e.slot = m_tail[f];
               m_ack[f] = seq + 32'(len);
               m_tail[f] = m_tail[f] + 4'd1;
               m_win[f] = (space > 17'(len)) ? space - 17'(len) : 17'd0;
               e.ack = m_ack[f]; e.win = m_win[f];
            end else begin
               e.acc = 1'b0; e.slot = '0; e.ack = m_ack[f];
               m_win[f] = space; e.win = space;
            end
            exp_q.push_back(e);
         end
      end
      target = done_cnt + 1;
      @(negedge clk);
      pkt_flowid = f; pkt_seq_num = seq; pkt_len = len; pkt_val = 1'b1;
      if (with_init) begin
         init_val = 1'b1; init_flowid = f; init_ack_num = iack; init_win = iwin;
         #1;
         chk("pkt_rdy_vs_init", 64'(pkt_rdy), 64'd0);
         @(posedge clk); #1;
         init_val = 1'b0;
      end
      while (!pkt_rdy && t < 50) begin @(negedge clk); t++; end
      if (!pkt_rdy) begin
         chk("pkt_rdy_timeout", 64'(pkt_rdy), 64'd1);
         pkt_val = 1'b0; abort = 1'b1;
      end else begin
         @(posedge clk); #1;
         hs_cyc = cyc; in_flight = 1'b1; pkt_val = 1'b0;
         if (!hang) begin
            t = 0;
            while (done_cnt < target && t < 300) begin @(negedge clk); t++; end
            if (done_cnt < target) begin
               chk("result_timeout", 64'(done_cnt), 64'(target));
               abort = 1'b1;
            end
         end
      end
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_ctrl"}, 64'({init_rdy, pkt_rdy, malloc_req_val, malloc_resp_rdy, res_val,
                             malloc_req_flowid, malloc_req_len}), 64'd0);
      chk({nm, "_res"}, 64'({res_flowid, res_accept, res_ack_num, res_slot_idx, res_win}), 64'd0);
   endtask

   // allocator model: checks requests against the scoreboard and answers per config
   initial begin : allocator
      logic [18:0] snap;
      cfg_t c;
      forever begin
         @(negedge clk);
         if (!rst && malloc_req_val) begin
            snap = {malloc_req_flowid, malloc_req_len};
            chk("mreq_expected", 64'(malloc_req_val), 64'(mreq_q.size() != 0));
            if (mreq_q.size() != 0) chk("mreq_fields", 64'(snap), 64'(mreq_q.pop_front()));
            if (cfg_q.size() != 0) c = cfg_q.pop_front();
            else begin c.succ = 1'b0; c.space = '0; c.req_wait = 0; c.resp_wait = 0; c.hang = 1'b0; end
            for (int i = 0; i < c.req_wait; i++) begin
               @(negedge clk);
               chk("mreq_stable", 64'({malloc_req_val, malloc_req_flowid, malloc_req_len}),
                   64'({1'b1, snap}));
            end
            malloc_req_rdy = 1'b1;
            @(negedge clk);
            malloc_req_rdy = 1'b0;
            if (!c.hang) begin
               for (int i = 0; i < c.resp_wait; i++) @(negedge clk);
               chk("mresp_rdy", 64'(malloc_resp_rdy), 64'd1);
               malloc_resp_val = 1'b1; malloc_resp_success = c.succ; malloc_resp_space = c.space;
               @(negedge clk);
               malloc_resp_val = 1'b0; malloc_resp_success = 1'b0; malloc_resp_space = '0;
            end
         end
      end
   end

   // result monitor: latency, stability, busy pkt_rdy and scoreboard compare
   bit          have_snap = 1'b0;
   int          rwait = 0;
   logic [56:0] rsnap;
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            have_snap = 1'b0; res_rdy = 1'b0;
         end else begin
            if (in_flight && !init_val) chk("pkt_rdy_busy", 64'(pkt_rdy), 64'd0);
            if (res_val) begin
               if (!have_snap) begin
                  have_snap = 1'b1;
                  rsnap = {res_flowid, res_accept, res_ack_num, res_slot_idx, res_win};
                  chk("res_expected", 64'(res_val), 64'(exp_q.size() != 0));
                  if (exp_q.size() != 0) begin
                     chk("res_latency", 64'(cyc - hs_cyc), 64'(exp_q[0].lat));
                     rwait = exp_q[0].res_wait;
                  end else rwait = 0;
               end else begin
                  chk("res_stable", 64'({res_flowid, res_accept, res_ack_num, res_slot_idx, res_win}),
                      64'(rsnap));
               end
               if (rwait > 0) begin
                  rwait--; res_rdy = 1'b0;
               end else begin
                  res_rdy = 1'b1;
                  @(posedge clk);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     chk("res_flowid", 64'(rsnap[56:54]), 64'(e.flow));
                     chk("res_accept", 64'(rsnap[53]), 64'(e.acc));
                     chk("res_ack_num", 64'(rsnap[52:21]), 64'(e.ack));
                     chk("res_slot_idx", 64'(rsnap[20:17]), 64'(e.slot));
                     chk("res_win", 64'(rsnap[16:0]), 64'(e.win));
                  end
                  have_snap = 1'b0; in_flight = 1'b0; done_cnt++;
               end
            end else begin
               res_rdy = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [2:0]  f;
      logic [31:0] seq;
      logic [3:0]  nh;
      int t;
      model_reset();
      #1 rst = 1'b1;
      #1 chk_outputs_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("init_rdy_after_reset", 64'(init_rdy), 64'd1);

      // basic accept, then out-of-order duplicate
      do_init(3'd2, 32'd1000, 17'd4096);
      send_pkt(3'd2, 32'd1000, 16'd100, 1'b1, 17'd4000, 0, 0, 0, 0, 0, '0, '0);
      send_pkt(3'd2, 32'd1200, 16'd50, 1'b1, 17'd4000, 0, 0, 0, 0, 0, '0, '0);

      // fill all slots, overflow, then free three and retry
      for (int i = 0; i < 7; i++)
         send_pkt(3'd2, m_ack[2], 16'd10, 1'b1, 17'd5000, 0, 0, 0, 0, 0, '0, '0);
      send_pkt(3'd2, m_ack[2], 16'd10, 1'b1, 17'd5000, 0, 0, 0, 0, 0, '0, '0);
      do_head(3'd2, 4'd3);
      send_pkt(3'd2, m_ack[2], 16'd10, 1'b1, 17'd5000, 0, 0, 0, 0, 0, '0, '0);

      // allocation failure and window saturation
      do_init(3'd4, 32'd77, 17'd900);
      send_pkt(3'd4, 32'd77, 16'd30, 1'b0, 17'd50, 0, 0, 0, 0, 0, '0, '0);
      send_pkt(3'd4, 32'd77, 16'd40, 1'b1, 17'd20, 0, 0, 0, 0, 0, '0, '0);

      // backpressure on request and result
      send_pkt(3'd4, m_ack[4], 16'd12, 1'b1, 17'd3000, 5, 2, 3, 0, 0, '0, '0);

      // init and pkt together: init must be taken first
      send_pkt(3'd6, 32'd500, 16'd8, 1'b1, 17'd800, 0, 0, 0, 0, 1, 32'd500, 17'd600);

      // ack wrap
      do_init(3'd5, 32'hFFFF_FFF0, 17'd1000);
      send_pkt(3'd5, 32'hFFFF_FFF0, 16'h20, 1'b1, 17'd1000, 0, 0, 0, 0, 0, '0, '0);

      // reset while waiting for the allocator response
      send_pkt(3'd5, 32'h10, 16'd5, 1'b1, 17'd100, 0, 0, 0, 1, 0, '0, '0);
      t = 0;
      while (!malloc_resp_rdy && t < 50) begin @(negedge clk); t++; end
      chk("reached_mresp", 64'(malloc_resp_rdy), 64'd1);
      rst = 1'b1;
      #1 chk_outputs_zero("mid_reset");
      exp_q.delete(); mreq_q.delete(); cfg_q.delete();
      in_flight = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("init_rdy_after_mid_reset", 64'(init_rdy), 64'd1);
      // cleared state: seq 0 on an un-initialised flow is in order
      send_pkt(3'd5, 32'd0, 16'd7, 1'b1, 17'd100, 0, 0, 0, 0, 0, '0, '0);

      // random traffic
      for (int i = 0; i < 8 && !abort; i++)
         do_init(3'(i), $urandom, 17'($urandom));
      for (int n = 0; n < 200 && !abort; n++) begin
         f = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) do_init(f, $urandom, 17'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            nh = m_tail[f] - 4'($urandom_range(0, 8));
            do_head(f, nh);
         end
         seq = ($urandom_range(0, 3) != 0) ? m_ack[f] : m_ack[f] + 32'($urandom_range(1, 500));
         send_pkt(f, seq, 16'($urandom_range(0, 1500)), 1'($urandom_range(0, 4) != 0),
                  17'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 0, 0, '0, '0);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size() + mreq_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
